// File: rtl/decoder_nx_pkg.sv
// Shared types and helpers for the decoder_nx one-hot line decoder.
package decoder_nx_pkg;

  localparam int DWELL_CW  = 24;
  localparam int MAX_OUT_W = 256;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Bits at or above `width` are always zero; callers size-cast the result.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int idx, input int width);
    logic [MAX_OUT_W-1:0] vec;
    vec = '0;
    for (int k = 0; k < MAX_OUT_W; k++) vec[k] = (k == idx) && (k < width);
    return vec;
  endfunction

  function automatic logic active_level(input logic active_low, input logic opt);
    return ~active_low ^ opt;
  endfunction

endpackage

// File: rtl/decoder_nx_scan_cnt.sv
// Dwell counter and index register: steps the index every DWELL cycles while
// not cleared, takes a direct load otherwise, and pulses wrap on OUT_W-1 -> 0.
module decoder_nx_scan_cnt
  import decoder_nx_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] idx,
  output logic [SEL_W-1:0] idx_nxt,
  output logic             wrap
);

  localparam logic [DWELL_CW-1:0] TC = DWELL_CW'(DWELL - 1);

  logic [DWELL_CW-1:0] cnt;
  logic [DWELL_CW-1:0] cnt_nxt;
  logic                tc;
  logic                step;

  assign tc   = (cnt == TC);
  assign step = ~clear & tc;

  always_comb begin
    idx_nxt = idx;
    if (load)      idx_nxt = load_val;
    else if (step) idx_nxt = idx + SEL_W'(1);
  end

  assign cnt_nxt = (clear | tc) ? '0 : cnt + DWELL_CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      wrap <= step & (idx == '1);
    end
  end

endmodule

// File: rtl/decoder_nx.sv
// Registered one-hot line decoder with direct select handshake and auto scan.
// Optional dead-time on index change is built when DECODER_NX_BLANK_EN is defined.
module decoder_nx
  import decoder_nx_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mode,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_sel_vld,
  output logic                o_sel_rdy,
  input  logic                i_opt,
  input  logic                i_en,
  output logic [2**SEL_W-1:0] o_y,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_wrap
);

  localparam int OUT_W = 2**SEL_W;

  mode_e            mode;
  logic [SEL_W-1:0] idx_nxt;
  logic             accept;
  logic             blanking;
  logic             act;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] y_nxt;

  assign mode   = mode_e'(i_mode);
  assign accept = i_sel_vld & o_sel_rdy;

  decoder_nx_scan_cnt #(
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_scan_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (mode != MODE_SCAN),
    .load     (accept),
    .load_val (i_sel),
    .idx      (o_idx),
    .idx_nxt  (idx_nxt),
    .wrap     (o_wrap)
  );

`ifdef DECODER_NX_BLANK_EN
  localparam int BW = $clog2(BLANK + 1);

  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] blank_nxt;

  // The blank window keeps running across mode changes.
  always_comb begin
    blank_nxt = '0;
    if (idx_nxt != o_idx)    blank_nxt = BW'(BLANK);
    else if (blank_cnt != 0) blank_nxt = blank_cnt - BW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) blank_cnt <= '0;
    else       blank_cnt <= blank_nxt;
  end

  assign blanking  = (blank_nxt != '0);
  assign o_sel_rdy = (mode == MODE_DIRECT) & (blank_cnt == '0);
`else
  logic unused_blank;
  assign unused_blank = ^BLANK;
  assign blanking     = 1'b0;
  assign o_sel_rdy    = (mode == MODE_DIRECT);
`endif

  assign act   = active_level(ACTIVE_LOW, i_opt);
  assign mask  = (i_en & ~blanking) ? OUT_W'(onehot(int'(idx_nxt), OUT_W)) : '0;
  assign y_nxt = act ? mask : ~mask;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_y <= {OUT_W{ACTIVE_LOW}};
    else       o_y <= y_nxt;
  end

endmodule

// File: tb/tb_decoder_nx.sv
// Randomized bench for decoder_nx against a cycle-level reference model.
module tb_decoder_nx;

  localparam int A_SW = 3;
  localparam bit A_AL = 1'b1;
  localparam int A_DW = 4;
  localparam int A_BL = 2;
  localparam int B_SW = 4;
  localparam bit B_AL = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, mode_a, vld_a, rdy_a, opt_a, en_a, wrap_a;
  logic [A_SW-1:0] sel_a, idx_a;
  logic [7:0]      y_a;
  logic            rst_b, mode_b, vld_b, rdy_b, opt_b, en_b, wrap_b;
  logic [B_SW-1:0] sel_b, idx_b;
  logic [15:0]     y_b;

  decoder_nx #(.SEL_W(A_SW), .ACTIVE_LOW(A_AL), .DWELL(A_DW), .BLANK(A_BL)) dut (
    .i_clk(clk), .i_rst(rst_a), .i_mode(mode_a), .i_sel(sel_a), .i_sel_vld(vld_a),
    .o_sel_rdy(rdy_a), .i_opt(opt_a), .i_en(en_a), .o_y(y_a), .o_idx(idx_a), .o_wrap(wrap_a)
  );

  decoder_nx #(.SEL_W(B_SW), .ACTIVE_LOW(B_AL), .DWELL(1), .BLANK(2)) dut16 (
    .i_clk(clk), .i_rst(rst_b), .i_mode(mode_b), .i_sel(sel_b), .i_sel_vld(vld_b),
    .o_sel_rdy(rdy_b), .i_opt(opt_b), .i_en(en_b), .o_y(y_b), .o_idx(idx_b), .o_wrap(wrap_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state for dut: current index, edges spent in scan at this index,
  // remaining dead-time cycles.
  int         m_idx, m_dwell, m_blank;
  bit         m_wrap;
  logic [7:0] m_y;

  function automatic logic [7:0] line_a(input int idx, input bit on, input bit opt);
    logic [7:0] v;
    bit         act;
    v   = on ? 8'(1 << idx) : 8'h00;
    act = (A_AL == 1'b0) ^ opt;
    return act ? v : ~v;
  endfunction

  task automatic model_reset_a();
    m_idx = 0; m_dwell = 0; m_blank = 0; m_wrap = 0;
    m_y = 8'hFF;
  endtask

  task automatic cyc_a();
    bit exp_rdy;
    int nidx;
    #1;
`ifdef DECODER_NX_BLANK_EN
    exp_rdy = !mode_a && (m_blank == 0);
`else
    exp_rdy = !mode_a;
`endif
    chk("a_rdy", 32'(rdy_a), 32'(exp_rdy));
    nidx   = m_idx;
    m_wrap = 0;
    if (mode_a) begin
      m_dwell++;
      if (m_dwell == A_DW) begin
        m_dwell = 0;
        nidx    = (m_idx + 1) % 8;
        m_wrap  = (m_idx == 7);
      end
    end else begin
      m_dwell = 0;
      if (vld_a && exp_rdy) nidx = int'(sel_a);
    end
`ifdef DECODER_NX_BLANK_EN
    if (nidx != m_idx)    m_blank = A_BL;
    else if (m_blank > 0) m_blank--;
`endif
    m_idx = nidx;
    m_y   = line_a(m_idx, en_a && (m_blank == 0), opt_a);
    @(posedge clk); #1;
    chk("a_idx",  32'(idx_a),  32'(m_idx));
    chk("a_wrap", 32'(wrap_a), 32'(m_wrap));
    chk("a_y",    32'(y_a),    32'(m_y));
  endtask

  task automatic wait_rdy_a();
    vld_a = 1'b0;
    for (int g = 0; g < 16 && !rdy_a; g++) cyc_a();
    chk("a_rdy_wait", 32'(rdy_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           bi, wraps;
    int           hits[16];
    logic [15:0]  bexp;
    bit           bwrap;

    rst_a = 1'b1; mode_a = 1'b0; vld_a = 1'b0; sel_a = '0; opt_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; mode_b = 1'b1; vld_b = 1'b0; sel_b = '0; opt_b = 1'b0; en_b = 1'b1;
    #3;
    chk("a_rst_y",    32'(y_a),    32'hFF);
    chk("a_rst_idx",  32'(idx_a),  32'd0);
    chk("a_rst_wrap", 32'(wrap_a), 32'd0);
    chk("b_rst_y",    32'(y_b),    32'h0);
    chk("b_rst_idx",  32'(idx_b),  32'd0);

    // SEL_W=4, DWELL=1, active-high lines: full scan every 16 cycles.
    rst_b = 1'b0;
    bi = 0; wraps = 0;
    for (int k = 0; k < 16; k++) hits[k] = 0;
    for (int c = 0; c < 48; c++) begin
      opt_b = 1'($urandom_range(0, 1));
      vld_b = 1'($urandom_range(0, 1));
      sel_b = 4'($urandom_range(0, 15));
      #1;
      chk("b_rdy", 32'(rdy_b), 32'd0);
      @(posedge clk); #1;
      bwrap = (bi == 15);
      bi    = (bi + 1) % 16;
      bexp  = 16'(1 << bi);
      if (opt_b) bexp = ~bexp;
      chk("b_idx",  32'(idx_b),  32'(bi));
      chk("b_wrap", 32'(wrap_b), 32'(bwrap));
      chk("b_y",    32'(y_b),    32'(bexp));
      if (wrap_b) wraps++;
      if (c < 16)
        for (int k = 0; k < 16; k++) if (y_b[k] == !opt_b) hits[k]++;
    end
    chk("b_wrap_count", 32'(wraps), 32'd3);
    for (int k = 0; k < 16; k++) chk($sformatf("b_hits%0d", k), 32'(hits[k]), 32'd1);

    // dut: direct select, polarity and enable.
    opt_a = 1'b0;
    rst_a = 1'b0;
    model_reset_a();
    sel_a = 3'd5; vld_a = 1'b1;
    cyc_a();
`ifndef DECODER_NX_BLANK_EN
    chk("dir_y5", 32'(y_a), 32'hDF);
`endif
    chk("dir_idx5", 32'(idx_a), 32'd5);
    vld_a = 1'b0; opt_a = 1'b1;
    cyc_a();
    cyc_a();
`ifndef DECODER_NX_BLANK_EN
    chk("opt_y", 32'(y_a), 32'h20);
`endif
    opt_a = 1'b0; en_a = 1'b0;
    cyc_a();
    chk("en_off_y", 32'(y_a), 32'hFF);
    en_a = 1'b1;

    // Scan from index 6 with stray select pulses.
    wait_rdy_a();
    sel_a = 3'd6; vld_a = 1'b1;
    cyc_a();
    vld_a = 1'b0; mode_a = 1'b1;
    for (int c = 0; c < 14; c++) begin
      vld_a = 1'($urandom_range(0, 1));
      sel_a = 3'($urandom_range(0, 7));
      cyc_a();
    end
    vld_a = 1'b0;

    // Leave scan at index 3, then re-accept the same index.
    for (int g = 0; g < 64 && idx_a != 3'd3; g++) cyc_a();
    chk("reach_idx3", 32'(idx_a), 32'd3);
    mode_a = 1'b0;
    cyc_a();
    chk("hold_idx3", 32'(idx_a), 32'd3);
    wait_rdy_a();
    sel_a = 3'd3; vld_a = 1'b1;
    cyc_a();
    chk("reacc_idx", 32'(idx_a), 32'd3);
    chk("reacc_y",   32'(y_a),   32'hF7);
    vld_a = 1'b0;

`ifdef DECODER_NX_BLANK_EN
    sel_a = 3'd1; vld_a = 1'b1;
    cyc_a();
    wait_rdy_a();
    sel_a = 3'd4; vld_a = 1'b1;
    cyc_a();
    chk("blk_idx", 32'(idx_a), 32'd4);
    chk("blk_y0",  32'(y_a),   32'hFF);
    vld_a = 1'b0;
    cyc_a();
    chk("blk_y1",  32'(y_a),   32'hFF);
    cyc_a();
    chk("blk_y2",  32'(y_a),   32'hEF);
`endif

    // Asynchronous reset in the middle of a dwell.
    mode_a = 1'b1;
    for (int c = 0; c < 6; c++) cyc_a();
    #1 rst_a = 1'b1;
    #1;
    chk("arst_y",    32'(y_a),    32'hFF);
    chk("arst_idx",  32'(idx_a),  32'd0);
    chk("arst_wrap", 32'(wrap_a), 32'd0);
    model_reset_a();
    rst_a = 1'b0;

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 15) == 0) opt_a = ~opt_a;
      if ($urandom_range(0, 15) == 0) en_a  = ~en_a;
      vld_a = 1'($urandom_range(0, 1));
      sel_a = 3'($urandom_range(0, 7));
      cyc_a();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
